nbin_feeder: RTL and testbench

- Producer side of the n0 interface.
- Buffers NBin entries (Tn input neurons, N bits each) arriving from the memory side in a circular queue.
- Replays each entry a programmable number of passes into the n0 cluster's i_nbin input.
- Tracks the fixed n0 pipeline latency, so downstream logic knows which n0 output cycles carry valid products.

---
 rtl/nbin_feeder.sv | 167 ++++++++++++++++
 tb/tb_nbin_feeder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/nbin_feeder.sv
// NBin producer for the n0 cluster: circular entry queue, multi-pass replay into i_nbin,
// and a fixed-latency valid pipe that marks which n0 output cycles carry products.
module nbin_feeder #(
    parameter int N      = 16,
    parameter int Tn     = 16,
    parameter int DEPTH  = 16,
    parameter int N0_LAT = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_valid,
    output logic                     o_wr_ready,
    input  logic [N*Tn-1:0]          i_wr_data,
    input  logic                     i_start,
    input  logic [$clog2(DEPTH):0]   i_num_entries,
    input  logic [7:0]               i_passes,
    output logic [N*Tn-1:0]          o_nbin,
    output logic                     o_issue,
    output logic                     o_n0_valid,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int W     = N * Tn;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              state_reg;
    logic [W-1:0]        mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [CNT_W-1:0]    num_reg;
    logic [7:0]          passes_reg;
    logic [7:0]          pass_cnt_reg;
    logic [CNT_W-1:0]    entry_cnt_reg;
    logic [W-1:0]        nbin_reg;
    logic                issue_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [N0_LAT-1:0]   valid_pipe_reg;

    logic push;
    logic pop;
    logic can_issue;
    logic last_pass;
    logic last_entry;

    // Ready looks only at the registered count, so a full queue stays closed during a pop.
    assign o_wr_ready = (count_reg < CNT_FULL);
    assign push       = i_wr_valid && o_wr_ready;
    assign can_issue  = (state_reg == ISSUE) && (count_reg != '0);
    assign last_pass  = (pass_cnt_reg == passes_reg - 8'd1);
    assign last_entry = (entry_cnt_reg == num_reg - CNT_ONE);
    assign pop        = can_issue && last_pass;

    assign o_nbin     = nbin_reg;
    assign o_issue    = issue_reg;
    assign o_n0_valid = valid_pipe_reg[N0_LAT-1];
    assign o_busy     = busy_reg;
    assign o_done     = done_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            num_reg       <= '0;
            passes_reg    <= 8'd1;
            pass_cnt_reg  <= '0;
            entry_cnt_reg <= '0;
            nbin_reg      <= '0;
            issue_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            issue_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        num_reg       <= i_num_entries;
                        passes_reg    <= (i_passes == 8'd0) ? 8'd1 : i_passes;
                        pass_cnt_reg  <= '0;
                        entry_cnt_reg <= '0;
                        if (i_num_entries == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ISSUE;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // An empty queue stalls the job; o_nbin keeps the last issued entry.
                    if (can_issue) begin
                        issue_reg <= 1'b1;
                        nbin_reg  <= mem[rd_ptr_reg];
                        if (last_pass) begin
                            pass_cnt_reg  <= '0;
                            entry_cnt_reg <= entry_cnt_reg + CNT_ONE;
                            if (last_entry) begin
                                state_reg <= DRAIN;
                            end
                        end else begin
                            pass_cnt_reg <= pass_cnt_reg + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    // The last issue is still in issue_reg on the first DRAIN cycle.
                    if ((valid_pipe_reg == '0) && !issue_reg) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_pipe_reg <= '0;
        end else begin
            valid_pipe_reg <= {valid_pipe_reg[N0_LAT-2:0], issue_reg};
        end
    end

endmodule

// File: tb/tb_nbin_feeder.sv
// Directed bench for nbin_feeder: multi-pass replay, stalls, full queue, latency pipe,
// empty jobs and reset in the middle of a job.
module tb_nbin_feeder;

    localparam int W = 256;

    logic          clk;
    logic          rst_n;
    logic          i_wr_valid;
    logic          o_wr_ready;
    logic [W-1:0]  i_wr_data;
    logic          i_start;
    logic [4:0]    i_num_entries;
    logic [7:0]    i_passes;
    logic [W-1:0]  o_nbin;
    logic          o_issue;
    logic          o_n0_valid;
    logic          o_busy;
    logic          o_done;

    int n_cmp = 0;
    int n_err = 0;

    nbin_feeder #(.N(16), .Tn(16), .DEPTH(16), .N0_LAT(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_wr_valid    (i_wr_valid),
        .o_wr_ready    (o_wr_ready),
        .i_wr_data     (i_wr_data),
        .i_start       (i_start),
        .i_num_entries (i_num_entries),
        .i_passes      (i_passes),
        .o_nbin        (o_nbin),
        .o_issue       (o_issue),
        .o_n0_valid    (o_n0_valid),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ent(input int i);
        logic [W-1:0] v;
        for (int k = 0; k < 16; k++) begin
            v[k*16 +: 16] = 16'(32'h0100 * i + k);
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [W-1:0] data);
        logic acc;
        i_wr_valid = 1'b1;
        i_wr_data  = data;
        acc = o_wr_ready;
        tick();
        i_wr_valid = 1'b0;
        $display("wr lane0=%h ready=%0b", data[15:0], acc);
    endtask

    task automatic start(input logic [4:0] num, input logic [7:0] passes);
        i_start       = 1'b1;
        i_num_entries = num;
        i_passes      = passes;
        tick();
        i_start = 1'b0;
        $display("start num=%0d passes=%0d", num, passes);
    endtask

    // Run from the cycle of the last issue until o_done; done arrives 7 cycles later.
    task automatic wait_done(input string tag);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk({tag, "_n0v"}, W'(o_n0_valid), W'(k == 5));
            chk({tag, "_done"}, W'(o_done), W'(k == 7));
        end
        tick();
        chk({tag, "_done_off"}, W'(o_done), W'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n         = 1'b0;
        i_wr_valid    = 1'b0;
        i_wr_data     = '0;
        i_start       = 1'b0;
        i_num_entries = '0;
        i_passes      = '0;
        tick();
        tick();
        chk("rst_ready", W'(o_wr_ready), W'(1));
        chk("rst_issue", W'(o_issue), W'(0));
        chk("rst_nbin", o_nbin, '0);
        chk("rst_busy", W'(o_busy), W'(0));
        chk("rst_done", W'(o_done), W'(0));
        chk("rst_n0v", W'(o_n0_valid), W'(0));
        rst_n = 1'b1;
        tick();

        // Four entries, two passes each, back to back.
        for (int i = 0; i < 4; i++) wr(ent(i));
        start(5'd4, 8'd2);
        chk("t1_busy", W'(o_busy), W'(1));
        chk("t1_pre_issue", W'(o_issue), W'(0));
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("t1_issue", W'(o_issue), W'(1));
            chk("t1_nbin", o_nbin, ent(j / 2));
            $display("issue lane0=%h", o_nbin[15:0]);
        end
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("t1_drain_issue", W'(o_issue), W'(0));
            chk("t1_n0v", W'(o_n0_valid), W'(k <= 5));
            chk("t1_done", W'(o_done), W'(k == 7));
        end
        chk("t1_busy_off", W'(o_busy), W'(0));
        chk("t1_count", W'(dut.count_reg), W'(0));
        tick();
        chk("t1_done_off", W'(o_done), W'(0));

        // Empty queue: each late write is issued one cycle after it lands.
        start(5'd3, 8'd1);
        for (int w = 0; w < 3; w++) begin
            wr(ent(4 + w));
            chk("t2_wait", W'(o_issue), W'(0));
            tick();
            chk("t2_issue", W'(o_issue), W'(1));
            chk("t2_nbin", o_nbin, ent(4 + w));
            tick();
            chk("t2_gap", W'(o_issue), W'(0));
            tick();
            chk("t2_hold", o_nbin, ent(4 + w));
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("t2_done", W'(o_done), W'(k == 5));
        end
        tick();

        // Fill the queue and confirm it refuses a 17th entry.
        for (int i = 0; i < 16; i++) wr(ent(32 + i));
        chk("t3_full", W'(o_wr_ready), W'(0));
        wr(ent(99));
        chk("t3_refused_cnt", W'(dut.count_reg), W'(16));
        start(5'd1, 8'd1);
        chk("t3_still_full", W'(o_wr_ready), W'(0));
        tick();
        chk("t3_issue", W'(o_issue), W'(1));
        chk("t3_nbin", o_nbin, ent(32));
        chk("t3_ready_back", W'(o_wr_ready), W'(1));
        wait_done("t3");

        // Single issue with passes=0 treated as one pass; valid pipe latency.
        do_reset();
        wr(ent(7));
        start(5'd1, 8'd0);
        tick();
        chk("t4_issue", W'(o_issue), W'(1));
        chk("t4_nbin", o_nbin, ent(7));
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("t4_no_reissue", W'(o_issue), W'(0));
            chk("t4_n0v", W'(o_n0_valid), W'(k == 5));
            chk("t4_done", W'(o_done), W'(k == 7));
        end
        tick();

        // Zero-entry job completes immediately.
        start(5'd0, 8'd1);
        chk("t5_done", W'(o_done), W'(1));
        chk("t5_busy", W'(o_busy), W'(0));
        chk("t5_issue", W'(o_issue), W'(0));
        tick();
        chk("t5_done_off", W'(o_done), W'(0));
        chk("t5_busy_off", W'(o_busy), W'(0));

        // Reset in the third ISSUE cycle.
        for (int i = 0; i < 4; i++) wr(ent(16 + i));
        start(5'd4, 8'd4);
        tick();
        tick();
        chk("t6_pre_issue", W'(o_issue), W'(1));
        rst_n = 1'b0;
        #1;
        chk("t6_issue", W'(o_issue), W'(0));
        chk("t6_nbin", o_nbin, '0);
        chk("t6_busy", W'(o_busy), W'(0));
        chk("t6_n0v", W'(o_n0_valid), W'(0));
        chk("t6_ready", W'(o_wr_ready), W'(1));
        chk("t6_count", W'(dut.count_reg), W'(0));
        tick();
        chk("t6_done_rst", W'(o_done), W'(0));
        rst_n = 1'b1;
        tick();
        chk("t6_done_after", W'(o_done), W'(0));
        wr(ent(21));
        start(5'd1, 8'd1);
        tick();
        chk("t6_new_issue", W'(o_issue), W'(1));
        chk("t6_new_nbin", o_nbin, ent(21));
        wait_done("t6_new");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
